second_largest_change_logger: RTL and testbench

Downstream consumer of the streaming second-largest tracker. It watches the tracker's registered output every cycle, detects each change of value, and tags the new value with a free-running cycle timestamp. Each tagged event is buffered in a small first-word-fall-through FIFO and drained through a valid/ready stream toward the host/debug interface. A sticky overflow flag reports dropped events.

---
 rtl/second_largest_change_logger.sv | 88 ++++++++
 tb/tb_second_largest_change_logger.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/second_largest_change_logger.sv
// Change logger: stamps each change of the tracker output with a free-running cycle
// count and queues {value, stamp} in a small FWFT FIFO drained by a valid/ready stream.
module second_largest_change_logger #(
  parameter int DATA_WIDTH  = 32,
  parameter int STAMP_WIDTH = 16,
  parameter int DEPTH       = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [DATA_WIDTH-1:0]  din,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [STAMP_WIDTH-1:0] out_stamp,
  output logic [CW-1:0]          count,
  output logic                   overflow
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]  data;
    logic [STAMP_WIDTH-1:0] stamp;
  } entry_t;

  entry_t mem_q [DEPTH];

  logic [DATA_WIDTH-1:0]  prev_q,  prev_d;
  logic [STAMP_WIDTH-1:0] stamp_q, stamp_d;
  logic [AW-1:0]          wptr_q,  wptr_d;
  logic [AW-1:0]          rptr_q,  rptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   ovf_q,   ovf_d;
  logic                   evt, pop, push;

  assign evt  = (din != prev_q);
  assign pop  = (count_q != '0) && out_ready;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push = evt && ((count_q < CW'(DEPTH)) || pop);

  always_comb begin
    prev_d  = prev_q;
    stamp_d = stamp_q + STAMP_WIDTH'(1);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (evt)  prev_d = din;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    if (evt && !push) ovf_d = 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev_q  <= '0;
      stamp_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      stamp_q <= stamp_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset; contents are only observed behind out_valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= '{data: din, stamp: stamp_q};
  end

  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rptr_q].data;
  assign out_stamp = mem_q[rptr_q].stamp;
  assign count     = count_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_second_largest_change_logger.sv
// Directed bench for second_largest_change_logger: hand-computed entries, stamps,
// FIFO full/overflow, stamp wrap (second instance, STAMP_WIDTH=4) and async reset.
module tb_second_largest_change_logger;

  localparam int DW = 32;
  localparam int SW = 16;
  localparam int D  = 8;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [DW-1:0] din = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [SW-1:0] out_stamp;
  logic [CW-1:0] count;
  logic          overflow;

  logic          v4;
  logic [DW-1:0] d4;
  logic [3:0]    s4;
  logic [CW-1:0] c4;
  logic          o4;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  second_largest_change_logger #(.DATA_WIDTH(DW), .STAMP_WIDTH(SW), .DEPTH(D)) dut (
    .clk(clk), .resetn(resetn), .din(din),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_stamp(out_stamp),
    .count(count), .overflow(overflow)
  );

  second_largest_change_logger #(.DATA_WIDTH(DW), .STAMP_WIDTH(4), .DEPTH(D)) dut4 (
    .clk(clk), .resetn(resetn), .din(din),
    .out_valid(v4), .out_ready(out_ready),
    .out_data(d4), .out_stamp(s4),
    .count(c4), .overflow(o4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Next posedge after return is stamp 0.
  task automatic do_reset();
    resetn = 1'b0;
    din = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    // Idle: din held at the reset value produces nothing.
    do_reset();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    repeat (20) tick();
    chk("idle_valid", 64'(out_valid), 64'd0);
    chk("idle_count", 64'(count), 64'd0);
    chk("idle_ovf", 64'(overflow), 64'd0);

    // Two changes at edges 3 and 7, drained immediately.
    do_reset();
    out_ready = 1'b1;
    repeat (3) tick();
    din = 32'd5;
    tick();
    chk("e3_valid", 64'(out_valid), 64'd1);
    chk("e3_data", 64'(out_data), 64'd5);
    chk("e3_stamp", 64'(out_stamp), 64'd3);
    tick();
    chk("e3_onecyc", 64'(out_valid), 64'd0);
    repeat (2) tick();
    din = 32'd9;
    tick();
    chk("e7_valid", 64'(out_valid), 64'd1);
    chk("e7_data", 64'(out_data), 64'd9);
    chk("e7_stamp", 64'(out_stamp), 64'd7);
    tick();
    chk("e7_onecyc", 64'(out_valid), 64'd0);

    // Ten consecutive changes into a stalled FIFO: 9 and 10 dropped.
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      din = DW'(k);
      tick();
    end
    chk("full_count", 64'(count), 64'd8);
    chk("full_ovf", 64'(overflow), 64'd1);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drain_data%0d", i), 64'(out_data), 64'(i));
      chk($sformatf("drain_stamp%0d", i), 64'(out_stamp), 64'(i - 1));
      tick();
    end
    chk("drain_empty", 64'(out_valid), 64'd0);
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_ovf", 64'(overflow), 64'd1);

    // Full with simultaneous push and pop; pointers wrap.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      din = DW'(11 + k);
      tick();
    end
    chk("pp_full", 64'(count), 64'd8);
    chk("pp_ovf0", 64'(overflow), 64'd0);
    out_ready = 1'b1;
    din = 32'd19;
    tick();
    chk("pp_count", 64'(count), 64'd8);
    chk("pp_ovf", 64'(overflow), 64'd0);
    for (int v = 12; v <= 19; v++) begin
      chk($sformatf("pp_data%0d", v), 64'(out_data), 64'(v));
      chk($sformatf("pp_stamp%0d", v), 64'(out_stamp), 64'(v - 11));
      tick();
    end
    chk("pp_empty", 64'(count), 64'd0);

    // Stamp wrap: change at edge 17 with a 4-bit stamp reads 1.
    do_reset();
    out_ready = 1'b0;
    repeat (17) tick();
    din = 32'd7;
    tick();
    chk("wrap_valid", 64'(v4), 64'd1);
    chk("wrap_data", 64'(d4), 64'd7);
    chk("wrap_stamp4", 64'(s4), 64'd1);
    chk("wrap_stamp16", 64'(out_stamp), 64'd17);

    // Async reset mid-drain with count=5 and overflow set.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      din = DW'(21 + k);
      tick();
    end
    chk("mr_ovf1", 64'(overflow), 64'd1);
    out_ready = 1'b1;
    repeat (3) tick();
    chk("mr_count5", 64'(count), 64'd5);
    chk("mr_head", 64'(out_data), 64'd24);
    resetn = 1'b0;
    #2;
    chk("mr_valid", 64'(out_valid), 64'd0);
    chk("mr_count", 64'(count), 64'd0);
    chk("mr_ovf", 64'(overflow), 64'd0);
    din = '0;
    out_ready = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) tick();
    chk("post_valid", 64'(out_valid), 64'd0);
    chk("post_count", 64'(count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
